seq_101_frame_tx: RTL and testbench

- Serial frame transmitter: the sending end for the team's "101" Moore sequence detectors.
- Accepts a parallel data word over a valid/ready handshake.
- Emits one bit per clock, MSB first: preamble 1,0,1, then the data word, then idle-low gap bits.
- Moore FSM: the serial output is decoded only from registered state and the shift register, so it has no combinational dependence on inputs.

---
 rtl/seq_pkg.sv | 18 +
 rtl/seq_piso.sv | 28 ++
 rtl/seq_101_frame_tx.sv | 120 ++++++++++++
 tb/tb_seq_101_frame_tx.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared types and constants for the "101" frame transmitter and its receivers.
// The optional parity state PAR is only reachable when SEQ_TX_PARITY_EN is defined.
package seq_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PRE1  = 3'd1,
    PRE0  = 3'd2,
    PRE1B = 3'd3,
    DATA  = 3'd4,
    PAR   = 3'd5,
    GAP   = 3'd6
  } state_t;

  localparam logic [2:0] PREAMBLE = 3'b101;
  localparam int         PRE_LEN  = 3;

endpackage

// File: rtl/seq_piso.sv
// Parallel-in serial-out shift register, MSB first, zero-filled on shift.
module seq_piso #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              shift,
  input  logic [DATA_W-1:0] din,
  output logic              msb
);

  logic [DATA_W-1:0] shreg;

  // Load wins over shift so a word can never be corrupted on the accepting edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg <= '0;
    end else if (load) begin
      shreg <= din;
    end else if (shift) begin
      shreg <= shreg << 1;
    end
  end

  assign msb = shreg[DATA_W-1];

endmodule

// File: rtl/seq_101_frame_tx.sv
// Serial "101"-preamble frame transmitter (Moore FSM, one bit per clock).
// Define SEQ_TX_PARITY_EN to append an even-parity bit after the payload.
module seq_101_frame_tx
  import seq_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int GAP_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              out,
  output logic              busy,
  output logic              done
);

  localparam int BCW = $clog2(DATA_W + 1);
  localparam int GCW = $clog2(GAP_CYCLES + 1);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(DATA_W - 1);
  localparam logic [GCW-1:0] GAP_LAST = GCW'(GAP_CYCLES - 1);

  state_t         state_q, state_d;
  logic [BCW-1:0] bit_cnt_q;
  logic [GCW-1:0] gap_cnt_q;
  logic           accept;
  logic           shift;
  logic           msb;
  logic           bit_last;
  logic           gap_last;

  assign in_ready = (state_q == IDLE);
  assign accept   = in_ready && in_valid;
  assign bit_last = (bit_cnt_q == BIT_LAST);
  assign gap_last = (gap_cnt_q == GAP_LAST);

  seq_piso #(.DATA_W(DATA_W)) u_piso (
    .clk   (clk),
    .reset (reset),
    .load  (accept),
    .shift (shift),
    .din   (in_data),
    .msb   (msb)
  );

`ifdef SEQ_TX_PARITY_EN
  logic par_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      par_q <= 1'b0;
    end else if (accept) begin
      par_q <= ^in_data;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Counters idle at zero outside their state, so they are cleared on entry and never wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
    end else begin
      bit_cnt_q <= (state_q == DATA) ? bit_cnt_q + 1'b1 : '0;
      gap_cnt_q <= (state_q == GAP)  ? gap_cnt_q + 1'b1 : '0;
    end
  end

  always_comb begin
    state_d = IDLE;
    shift   = 1'b0;
    case (state_q)
      IDLE:  state_d = accept ? PRE1 : IDLE;
      PRE1:  state_d = PRE0;
      PRE0:  state_d = PRE1B;
      PRE1B: state_d = DATA;
      DATA: begin
        shift = 1'b1;
`ifdef SEQ_TX_PARITY_EN
        state_d = bit_last ? PAR : DATA;
`else
        state_d = bit_last ? GAP : DATA;
`endif
      end
`ifdef SEQ_TX_PARITY_EN
      PAR:   state_d = GAP;
`endif
      GAP:   state_d = gap_last ? IDLE : GAP;
      default: state_d = IDLE;
    endcase
  end

  // Outputs depend only on registered state, so reset forces out low immediately.
  always_comb begin
    out = 1'b0;
    case (state_q)
      PRE1:  out = PREAMBLE[PRE_LEN-1];
      PRE0:  out = PREAMBLE[PRE_LEN-2];
      PRE1B: out = PREAMBLE[PRE_LEN-3];
      DATA:  out = msb;
`ifdef SEQ_TX_PARITY_EN
      PAR:   out = par_q;
`endif
      default: out = 1'b0;
    endcase
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == GAP) && gap_last;

endmodule

// File: tb/tb_seq_101_frame_tx.sv
// Scoreboard bench for seq_101_frame_tx (DATA_W=8, GAP_CYCLES=2); honours SEQ_TX_PARITY_EN.
module tb_seq_101_frame_tx;

  typedef struct packed {
    logic o;
    logic d;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready, out, busy, done;

  int checks = 0;
  int failures = 0;

  exp_t sb[$];
  int   frames = 0;
  int   idle_run = 0;
  int   last_idle_run = -1;
  int   pos = 0;
  bit   first_hit = 1'b0;
  bit   prev_busy = 1'b0;
  logic [2:0] hist = 3'b000;

  seq_101_frame_tx #(.DATA_W(8), .GAP_CYCLES(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out      (out),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Hand-computed frame: pat = preamble, payload MSB first, gap bits; par is the even-parity bit.
  task automatic push_frame(input logic [12:0] pat, input logic par);
    exp_t e;
    for (int i = 12; i >= 2; i--) begin
      e.o = pat[i]; e.d = 1'b0; sb.push_back(e);
    end
`ifdef SEQ_TX_PARITY_EN
    e.o = par; e.d = 1'b0; sb.push_back(e);
`else
    if (par) e.d = 1'b0;
`endif
    e.o = pat[1]; e.d = 1'b0; sb.push_back(e);
    e.o = pat[0]; e.d = 1'b1; sb.push_back(e);
  endtask

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++; failures++;
      $display("FAIL wait_ready: in_ready got 0 expected 1 after 100 cycles");
    end
  endtask

  task automatic send(input logic [7:0] w, input logic [12:0] pat, input logic par);
    wait_ready();
    in_data  = w;
    in_valid = 1'b1;
    push_frame(pat, par);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    check("drain_queue_empty", sb.size(), 0);
  endtask

  // Monitor: pops one expected bit per busy cycle; models a 101 detector on the loopback.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      hist      = 3'b000;
      prev_busy = 1'b0;
      idle_run  = 0;
    end else begin
      hist = {hist[1:0], out};
      if (busy) begin
        if (!prev_busy) begin
          frames++;
          last_idle_run = idle_run;
          idle_run  = 0;
          pos       = 0;
          first_hit = 1'b0;
        end
        pos++;
        if (sb.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_frame_bit: got out=%0d with no expected bit queued", out);
        end else begin
          e = sb.pop_front();
          check("frame_bit{out,done,in_ready}", {29'd0, out, done, in_ready}, {29'd0, e.o, e.d, 1'b0});
        end
        if (hist == 3'b101 && !first_hit) begin
          first_hit = 1'b1;
          check("detector_first_hit_pos", pos, 3);
        end
      end else begin
        idle_run++;
        check("idle_out_done", {30'd0, out, done}, 0);
      end
      prev_busy = busy;
    end
  end

  initial begin
    int f0;
    #3;
    check("reset_out", out, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_in_ready", in_ready, 1);
    @(negedge clk);
    reset = 1'b1;

    // Basic frame A5
    send(8'hA5, 13'b101_10100101_00, 1'b0);
    wait_drain();

    // in_valid held high across two words
    wait_ready();
    in_data  = 8'hFF;
    in_valid = 1'b1;
    push_frame(13'b101_11111111_00, 1'b0);
    @(posedge clk);
    #1;
    in_data = 8'h00;
    push_frame(13'b101_00000000_00, 1'b0);
    wait_ready();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_cycles_between_frames", last_idle_run, 1);
    wait_drain();

    // Stray in_valid pulse during DATA must be ignored
    f0 = frames;
    send(8'h5A, 13'b101_01011010_00, 1'b0);
    repeat (6) @(negedge clk);
    in_data  = 8'hC3;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    wait_drain();
    repeat (4) @(negedge clk);
    check("no_extra_frame", frames - f0, 1);

    // Payload 07 (parity 1 when enabled)
    send(8'h07, 13'b101_00000111_00, 1'b1);
    wait_drain();

    // Reset during DATA bit 4 of frame 3C
    send(8'h3C, 13'b101_00111100_00, 1'b0);
    repeat (7) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("abort_out", out, 0);
    check("abort_busy", busy, 0);
    check("abort_in_ready", in_ready, 1);
    check("abort_done", done, 0);
    sb.delete();
    repeat (3) @(negedge clk);
    check("abort_held_busy", busy, 0);
    reset = 1'b1;

    // Frame after abort
    send(8'h81, 13'b101_10000001_00, 1'b0);
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation time %0t exceeded limit", $time);
    $fatal(1, "timeout");
  end

endmodule
